// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle between sync_fifo_flex and its producer/consumer.
// Both ports of the FIFO share one clock, so the bundle carries no clock.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
        input  count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO for any DEPTH >= 2 with count, thresholds, error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 10,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_flex_if.slave  f
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  full;
    logic                  empty;
    logic                  rd_ok;
    logic                  wr_ok;

    assign full  = (cnt == DEPTH_C);
    assign empty = (cnt == '0);
    assign rd_ok = f.rd_en & ~empty;
    assign wr_ok = f.wr_en & (~full | rd_ok);

    always_comb begin
        cnt_nxt = cnt;
        if (wr_ok && !rd_ok) begin
            cnt_nxt = cnt + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    // Explicit wrap so non-power-of-2 depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (f.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PW'(1);
            end
            cnt   <= cnt_nxt;
            ovf_q <= f.wr_en & full & ~rd_ok;
            udf_q <= f.rd_en & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !f.flush) begin
            mem[wr_ptr] <= f.data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign f.data_out = empty ? '0 : mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_ok && !f.flush) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign f.data_out = dout_q;
`endif

    assign f.FULL         = full;
    assign f.EMPTY        = empty;
    assign f.ALMOST_FULL  = (cnt >= AF_C);
    assign f.ALMOST_EMPTY = (cnt <= AE_C);
    assign f.count        = cnt;
    assign f.overflow     = ovf_q;
    assign f.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex (DEPTH=10, DATA_WIDTH=8).
// Expectations follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_sync_fifo_flex;
`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(10)) bus ();

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .f     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // flags packed as {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, overflow, underflow}
    function automatic logic [5:0] flags();
        return {bus.FULL, bus.EMPTY, bus.ALMOST_FULL, bus.ALMOST_EMPTY,
                bus.overflow, bus.underflow};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] fl;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_in = 8'h00;
        #12;
        fl = flags();
        checks++;
        if (fl !== 6'b010100) begin
            errors++;
            $display("FAIL reset_flags: got %b exp %b", fl, 6'b010100);
        end
        checks++;
        if (bus.count !== 4'd0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_cnt_data: got %0d/%h exp 0/00",
                     bus.count, bus.data_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        fl = flags();
        checks++;
        if (fl !== 6'b010101 || bus.count !== 4'd0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL underflow_pulse: got %b/%0d/%h exp 010101/0/00",
                     fl, bus.count, bus.data_out);
        end
        step();
        checks++;
        if (bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b exp 0", bus.underflow);
        end
    endtask

    task automatic test_fill();
        logic [5:0] fl;
        logic [5:0] ex;
        logic [7:0] dexp;
        dexp = FWFT ? 8'h01 : 8'h00;
        for (int i = 1; i <= 10; i++) begin
            bus.wr_en = 1'b1;
            bus.data_in = 8'(i);
            step();
            ex = {i == 10, 1'b0, i >= 8, i <= 2, 2'b00};
            fl = flags();
            checks++;
            if (fl !== ex || bus.count !== 4'(i) || bus.data_out !== dexp) begin
                errors++;
                $display("FAIL fill_%0d: got %b/%0d/%h exp %b/%0d/%h",
                         i, fl, bus.count, bus.data_out, ex, i, dexp);
            end
        end
        bus.data_in = 8'hFF;
        step();
        bus.wr_en = 1'b0;
        fl = flags();
        checks++;
        if (fl !== 6'b101010 || bus.count !== 4'd10) begin
            errors++;
            $display("FAIL overflow_pulse: got %b/%0d exp 101010/10",
                     fl, bus.count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [13];
        logic [7:0] ex;
        for (int k = 0; k < 10; k++) seq[k] = 8'(k + 1);
        for (int k = 10; k < 13; k++) seq[k] = 8'(8'h20 + k - 10);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.data_in = 8'(8'h20 + k);
            step();
            ex = FWFT ? seq[k + 1] : seq[k];
            checks++;
            if (bus.data_out !== ex || bus.count !== 4'd10 ||
                bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: got %h/%0d/%b%b exp %h/10/00",
                         k, bus.data_out, bus.count, bus.overflow,
                         bus.underflow, ex);
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic test_flush();
        logic [5:0] fl;
        logic [7:0] ex;
        bus.rd_en = 1'b1;
        for (int k = 0; k < 5; k++) step();
        bus.rd_en = 1'b0;
        ex = FWFT ? 8'h27 : 8'h26;
        checks++;
        if (bus.count !== 4'd5 || bus.data_out !== ex) begin
            errors++;
            $display("FAIL preflush: got %0d/%h exp 5/%h",
                     bus.count, bus.data_out, ex);
        end
        bus.flush = 1'b1;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.data_in = 8'hAA;
        step();
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        ex = FWFT ? 8'h00 : 8'h26;
        fl = flags();
        checks++;
        if (fl !== 6'b010100 || bus.count !== 4'd0 || bus.data_out !== ex) begin
            errors++;
            $display("FAIL flush: got %b/%0d/%h exp 010100/0/%h",
                     fl, bus.count, bus.data_out, ex);
        end
        step();
        fl = flags();
        checks++;
        if (fl !== 6'b010100 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL postflush: got %b/%0d exp 010100/0",
                     fl, bus.count);
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] fl;
        logic [7:0] ex;
        bus.wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.data_in = 8'(8'h55 + k);
            step();
        end
        bus.rd_en = 1'b1;
        bus.data_in = 8'h58;
        step();
        ex = FWFT ? 8'h56 : 8'h55;
        checks++;
        if (bus.count !== 4'd3 || bus.data_out !== ex) begin
            errors++;
            $display("FAIL prereset: got %0d/%h exp 3/%h",
                     bus.count, bus.data_out, ex);
        end
        #2 rst_n = 1'b0;
        #1;
        fl = flags();
        checks++;
        if (fl !== 6'b010100 || bus.count !== 4'd0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b/%0d/%h exp 010100/0/00",
                     fl, bus.count, bus.data_out);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.count !== 4'd0 || bus.EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: got %0d/%b exp 0/1",
                     bus.count, bus.EMPTY);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
